keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad, debounces presses and releases, and encodes the key into a 4-bit calculator code.
- Directly upstream of the input-unit digit shift register: key_code drives its `in` port and key_trig drives its `trig` port.
- key_trig is a clean, glitch-free registered level. Its rising edge is the downstream clock event, so key_code must be stable before key_trig rises.

---
 rtl/keypad_pkg.sv | 39 +++
 rtl/sync_2ff.sv | 28 ++
 rtl/keypad_scanner.sv | 130 +++++++++++++
 tb/tb_keypad_scanner.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad types and key codes.
// Used by the scanner and the input-unit digit register.
package keypad_pkg;

    typedef enum logic [2:0] {
        SCAN,
        DEBOUNCE,
        LOAD,
        PRESSED,
        RELEASE
    } state_e;

    localparam logic [3:0] KEY_CLR = 4'hE;
    localparam logic [3:0] KEY_EQ  = 4'hF;

    // Entry index is row*4+col; entry 0 is the rightmost nibble.
    localparam logic [15:0][3:0] KEYMAP = {
        4'hD, KEY_EQ, 4'h0, KEY_CLR,
        4'hC, 4'h9,   4'h8, 4'h7,
        4'hB, 4'h6,   4'h5, 4'h4,
        4'hA, 4'h3,   4'h2, 4'h1
    };

    // True when exactly one column line is pulled low.
    function automatic logic one_cold(input logic [3:0] v);
        return ($countones(~v) == 1);
    endfunction

    // Index of the low column; only meaningful when one_cold(v).
    function automatic logic [1:0] col_of(input logic [3:0] v);
        logic [1:0] c;
        c = 2'd0;
        if (!v[1]) c = 2'd1;
        if (!v[2]) c = 2'd2;
        if (!v[3]) c = 2'd3;
        return c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Resets to all-ones (idle level of pulled-up lines).
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Capture the asynchronous input through two stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce.
// key_code settles one cycle before key_trig rises.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols_n,
    output logic [3:0] rows_n,
    output logic [3:0] key_code,
    output logic       key_trig
);

    import keypad_pkg::*;

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    state_e        state_q, state_d;
    logic [1:0]    row_q, row_d;
    logic [1:0]    col_q, col_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [3:0]    code_q, code_d;
    logic          trig_q, trig_d;
    logic [3:0]    cols_s;
    logic [3:0]    pat;
    logic          col_hi;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (cols_n),
        .q_o   (cols_s)
    );

    assign pat    = ~(4'b0001 << col_q);
    assign col_hi = cols_s[col_q];

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SCAN;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            scan_q  <= '0;
            deb_q   <= '0;
            code_q  <= 4'h0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            scan_q  <= scan_d;
            deb_q   <= deb_d;
            code_q  <= code_d;
            trig_q  <= trig_d;
        end
    end

    // Scan, debounce and release sequencing.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        scan_d  = scan_q;
        deb_d   = deb_q;
        code_d  = code_q;
        trig_d  = trig_q;
        unique case (state_q)
            SCAN: begin
                if (scan_q == SCAN_LAST) begin
                    scan_d = '0;
                    if (one_cold(cols_s)) begin
                        col_d   = col_of(cols_s);
                        deb_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (cols_s != pat) begin
                    scan_d  = '0;
                    state_d = SCAN;
                end else if (deb_q == DEB_LAST) begin
                    state_d = LOAD;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            LOAD: begin
                code_d  = KEYMAP[{row_q, col_q}];
                state_d = PRESSED;
            end
            PRESSED: begin
                trig_d = 1'b1;
                if (col_hi) begin
                    deb_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!col_hi) begin
                    deb_d   = '0;
                    state_d = PRESSED;
                end else if (deb_q == DEB_LAST) begin
                    trig_d  = 1'b0;
                    row_d   = row_q + 2'd1;
                    scan_d  = '0;
                    state_d = SCAN;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    assign rows_n   = ~(4'b0001 << row_q);
    assign key_code = code_q;
    assign key_trig = trig_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner.
// Keypad modelled as a switch matrix between rows_n and cols_n.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] cols_n;
    logic [3:0] rows_n;
    logic [3:0] key_code;
    logic       key_trig;

    logic [15:0] pressed;

    int checks;
    int errors;

    int         rise_cnt;
    int         fall_cnt;
    int         lead_err;
    int         hold_err;
    logic       trig_prev;
    logic [3:0] code_prev;
    logic [3:0] rise_code;
    logic [3:0] rows_seen;

    typedef struct {
        int         row;
        int         col;
        logic [3:0] code;
    } vec_t;

    vec_t tbl[16];

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cols_n   (cols_n),
        .rows_n   (rows_n),
        .key_code (key_code),
        .key_trig (key_trig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Closed switch at (r,c) pulls column c low while row r is driven.
    always_comb begin
        cols_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!rows_n[r] && pressed[r*4+c])
                    cols_n[c] = 1'b0;
    end

    // Edge monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (key_trig && !trig_prev) begin
            rise_cnt++;
            rise_code = key_code;
            if (key_code != code_prev) lead_err++;
        end
        if (!key_trig && trig_prev) fall_cnt++;
        if (key_trig && trig_prev && key_code != code_prev) hold_err++;
        rows_seen = rows_seen | ~rows_n;
        trig_prev = key_trig;
        code_prev = key_code;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic key(input int r, input int c, input logic v);
        pressed[r*4+c] = v;
    endtask

    // Key legend as printed on the keypad.
    function automatic logic [3:0] model_code(input int r, input int c);
        string legend;
        byte   ch;
        legend = "123A456B789C*0#D";
        ch = legend[r*4+c];
        if (ch >= 8'd48 && ch <= 8'd57) return 4'(ch - 8'd48);
        if (ch == 8'd42) return 4'hE;
        if (ch == 8'd35) return 4'hF;
        return 4'(ch - 8'd65 + 8'd10);
    endfunction

    initial begin
        int base;
        int fc;
        int r;
        int c;
        int dur;
        int tap;
        logic [3:0] last_code;

        tbl[0]  = '{0, 0, 4'h1}; tbl[1]  = '{0, 1, 4'h2};
        tbl[2]  = '{0, 2, 4'h3}; tbl[3]  = '{0, 3, 4'hA};
        tbl[4]  = '{1, 0, 4'h4}; tbl[5]  = '{1, 1, 4'h5};
        tbl[6]  = '{1, 2, 4'h6}; tbl[7]  = '{1, 3, 4'hB};
        tbl[8]  = '{2, 0, 4'h7}; tbl[9]  = '{2, 1, 4'h8};
        tbl[10] = '{2, 2, 4'h9}; tbl[11] = '{2, 3, 4'hC};
        tbl[12] = '{3, 0, 4'hE}; tbl[13] = '{3, 1, 4'h0};
        tbl[14] = '{3, 2, 4'hF}; tbl[15] = '{3, 3, 4'hD};

        checks = 0; errors = 0;
        rise_cnt = 0; fall_cnt = 0; lead_err = 0; hold_err = 0;
        trig_prev = 1'b0; code_prev = 4'h0; rise_code = 4'h0;
        rows_seen = 4'h0;
        pressed = 16'h0;
        reset = 1'b0;
        #1;
        chk("reset_rows", rows_n, 4'b1110);
        chk("reset_trig", key_trig, 0);
        chk("reset_code", key_code, 0);
        tick(3);
        reset = 1'b1;

        // Reset mid-scan.
        tick(6);
        reset = 1'b0;
        #1;
        chk("midscan_rows", rows_n, 4'b1110);
        chk("midscan_trig", key_trig, 0);
        tick(2);
        reset = 1'b1;
        tick(2);

        // Every key once, from the table.
        for (int i = 0; i < 16; i++) begin
            base = rise_cnt;
            key(tbl[i].row, tbl[i].col, 1'b1);
            tick(45);
            chk($sformatf("tbl%0d_rises", i), rise_cnt - base, 1);
            chk($sformatf("tbl%0d_code", i), rise_code, tbl[i].code);
            chk($sformatf("tbl%0d_trig_hi", i), key_trig, 1);
            key(tbl[i].row, tbl[i].col, 1'b0);
            tick(25);
            chk($sformatf("tbl%0d_trig_lo", i), key_trig, 0);
            chk($sformatf("tbl%0d_code_kept", i), key_code, tbl[i].code);
        end

        // Clean press row1/col2, then reset mid-press.
        base = rise_cnt;
        key(1, 2, 1'b1);
        tick(40);
        chk("clean_rises", rise_cnt - base, 1);
        chk("clean_code", rise_code, 4'h6);
        key(1, 2, 1'b0);
        tick(20);
        chk("clean_trig_lo", key_trig, 0);
        chk("clean_code_kept", key_code, 4'h6);
        key(1, 2, 1'b1);
        tick(40);
        chk("midpress_trig_hi", key_trig, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("midpress_trig", key_trig, 0);
        chk("midpress_code", key_code, 0);
        chk("midpress_rows", rows_n, 4'b1110);
        key(1, 2, 1'b0);
        tick(2);
        reset = 1'b1;
        tick(2);

        // Bouncy press on row3/col0.
        base = rise_cnt;
        key(3, 0, 1'b1); tick(3);
        key(3, 0, 1'b0); tick(2);
        key(3, 0, 1'b1); tick(5);
        key(3, 0, 1'b0); tick(2);
        key(3, 0, 1'b1); tick(4);
        key(3, 0, 1'b0); tick(2);
        chk("bounce_no_rise", rise_cnt - base, 0);
        key(3, 0, 1'b1);
        tick(40);
        chk("bounce_rises", rise_cnt - base, 1);
        chk("bounce_code", rise_code, 4'hE);
        key(3, 0, 1'b0);
        tick(25);

        // Two keys in one row are rejected.
        base = rise_cnt;
        key(0, 1, 1'b1);
        key(0, 3, 1'b1);
        rows_seen = 4'h0;
        tick(60);
        chk("multi_rises", rise_cnt - base, 0);
        chk("multi_trig", key_trig, 0);
        chk("multi_rows_cycle", rows_seen, 4'hF);
        key(0, 1, 1'b0);
        key(0, 3, 1'b0);
        tick(10);

        // Hold key 1, add key 8, release key 1.
        base = rise_cnt;
        key(0, 0, 1'b1);
        tick(40);
        chk("hold1_rises", rise_cnt - base, 1);
        chk("hold1_code", rise_code, 4'h1);
        key(2, 1, 1'b1);
        tick(40);
        chk("hold2_rises", rise_cnt - base, 1);
        chk("hold2_code", key_code, 4'h1);
        chk("hold2_trig", key_trig, 1);
        key(0, 0, 1'b0);
        tick(60);
        chk("second_rises", rise_cnt - base, 2);
        chk("second_code", rise_code, 4'h8);
        key(2, 1, 1'b0);
        tick(25);
        chk("second_trig_lo", key_trig, 0);

        // Release bounce: 2-cycle low glitch during release.
        key(1, 1, 1'b1);
        tick(40);
        chk("relb_trig_hi", key_trig, 1);
        key(1, 1, 1'b0);
        tick(4);
        key(1, 1, 1'b1);
        tick(2);
        key(1, 1, 1'b0);
        fc = fall_cnt;
        tick(9);
        chk("relb_still_hi", key_trig, 1);
        chk("relb_no_fall", fall_cnt - fc, 0);
        tick(3);
        chk("relb_trig_lo", key_trig, 0);
        chk("relb_code", key_code, 4'h5);
        tick(10);

        // Random taps and holds against the legend model.
        last_code = key_code;
        for (int i = 0; i < 14; i++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            tap = ($urandom_range(0, 3) == 0) ? 1 : 0;
            dur = tap ? $urandom_range(1, 6) : $urandom_range(35, 70);
            base = rise_cnt;
            key(r, c, 1'b1);
            tick(dur);
            key(r, c, 1'b0);
            tick($urandom_range(25, 40));
            if (tap == 0) last_code = model_code(r, c);
            chk($sformatf("rnd%0d_rises", i), rise_cnt - base, tap ? 0 : 1);
            chk($sformatf("rnd%0d_code", i), key_code, last_code);
            chk($sformatf("rnd%0d_trig_lo", i), key_trig, 0);
        end

        chk("lead_one_cycle", lead_err, 0);
        chk("code_stable_while_trig", hold_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
